dffe_skid_slice: RTL and testbench

- Two-entry register slice (skid buffer) with valid/ready handshakes on both sides.
- Sits between a producer and a consumer on any datapath that needs the timing cut.
- Registers data, valid and ready so that no combinational path crosses it in either direction.
- Runs at full throughput of one beat per cycle, with one cycle of forward latency.

---
 rtl/dffe_skid_slice.sv | 67 ++++++
 tb/tb_dffe_skid_slice.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dffe_skid_slice.sv
// dffe_skid_slice: two-entry valid/ready register slice that cuts every combinational path.
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   s_valid/s_data  upstream beat offer
//   s_ready         registered upstream accept
//   m_valid/m_data  registered downstream beat
//   m_ready         downstream accept
module dffe_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t st, nxt;
  logic [WIDTH-1:0] skid;
  logic in, out, ld_main, ld_skid, from_skid;
  assign in  = s_valid & s_ready;
  assign out = m_valid & m_ready;
  always_comb begin
    nxt       = st;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (st)
      EMPTY: begin
        ld_main = in;
        nxt     = in ? ONE : EMPTY;
      end
      ONE: begin
        ld_main = in & out;
        ld_skid = in & ~out;
        nxt     = (in & ~out) ? FULL : (~in & out) ? EMPTY : ONE;
      end
      FULL: begin
        ld_main   = out;
        from_skid = out;
        nxt       = out ? ONE : FULL;
      end
      default: nxt = EMPTY;
    endcase
  end
  // Handshake outputs are registered copies of the next occupancy so that
  // neither s_ready nor m_valid depends combinationally on the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
      m_data  <= '0;
      skid    <= '0;
    end else begin
      st      <= nxt;
      m_valid <= nxt != EMPTY;
      s_ready <= nxt != FULL;
      if (ld_main) m_data <= from_skid ? skid : s_data;
      if (ld_skid) skid <= s_data;
    end
  end
endmodule

// File: tb/tb_dffe_skid_slice.sv
// tb_dffe_skid_slice: directed and random-stall checks of the skid slice.
module tb_dffe_skid_slice;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dffe_skid_slice #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic v, input logic r, input logic [7:0] d);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(v));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(r));
    chk({tag, "_m_data"}, 32'(m_data), 32'(d));
  endtask
  initial begin
    int in_cnt, out_cnt, cyc;
    logic pin, pout, pv, pr;
    logic [7:0] pd;
    #2 rst_n = 1'b0;
    #1 outs("reset", 1'b0, 1'b1, 8'h00);
    #7 rst_n = 1'b1;
    tick();
    outs("idle", 1'b0, 1'b1, 8'h00);
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
    tick();
    s_data = 8'h22;
    tick();
    s_valid = 1'b0;
    outs("full_11", 1'b1, 1'b0, 8'h11);
    #2 rst_n = 1'b0;
    #1 outs("async_rst", 1'b0, 1'b1, 8'h00);
    #1 rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h33; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    outs("post_rst_33", 1'b1, 1'b1, 8'h33);
    tick();
    outs("post_rst_drain", 1'b0, 1'b1, 8'h33);
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      tick();
      outs("stream", 1'b1, 1'b1, 8'(i));
    end
    s_valid = 1'b0;
    tick();
    outs("stream_end", 1'b0, 1'b1, 8'h10);
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hA1;
    tick();
    outs("bp_a1", 1'b1, 1'b1, 8'hA1);
    s_data = 8'hA2;
    tick();
    outs("bp_a2", 1'b1, 1'b0, 8'hA1);
    s_data = 8'hA3;
    tick();
    outs("bp_a3_held", 1'b1, 1'b0, 8'hA1);
    tick();
    outs("bp_stable", 1'b1, 1'b0, 8'hA1);
    m_ready = 1'b1;
    tick();
    outs("drain_a2", 1'b1, 1'b1, 8'hA2);
    tick();
    outs("drain_a3", 1'b1, 1'b1, 8'hA3);
    s_valid = 1'b0;
    tick();
    outs("drain_empty", 1'b0, 1'b1, 8'hA3);
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
    tick();
    outs("sim_5a", 1'b1, 1'b1, 8'h5A);
    s_data = 8'hC3; m_ready = 1'b1;
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    outs("sim_c3", 1'b1, 1'b1, 8'hC3);
    chk("sim_skid_untouched", 32'(dut.skid), 32'hA2);
    m_ready = 1'b1;
    tick();
    outs("sim_drain", 1'b0, 1'b1, 8'hC3);
    in_cnt = 0; out_cnt = 0; cyc = 0;
    s_valid = 1'b0; m_ready = 1'b0;
    while (out_cnt < 1000 && cyc < 20000) begin
      if (!s_valid) s_valid = ($urandom_range(0, 1) == 1) && (in_cnt < 1000);
      s_data = in_cnt[7:0];
      m_ready = $urandom_range(0, 1) == 1;
      pin = s_valid & s_ready;
      pout = m_valid & m_ready;
      pv = m_valid; pr = m_ready; pd = m_data;
      tick();
      cyc++;
      if (pout) begin
        chk("rand_order", 32'(pd), 32'(out_cnt[7:0]));
        out_cnt++;
      end
      if (pv && !pr) begin
        chk("rand_stable_data", 32'(m_data), 32'(pd));
        chk("rand_stable_valid", 32'(m_valid), 32'd1);
      end
      if (pin) begin
        in_cnt++;
        s_valid = 1'b0;
      end
    end
    chk("rand_out_count", 32'(out_cnt), 32'd1000);
    chk("rand_in_count", 32'(in_cnt), 32'd1000);
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    outs("rand_final", 1'b0, 1'b1, 8'(999));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
